// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: default sizing, wait-counter
// width and the debug read-response state encoding.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF   = 13;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 8;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_DONE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating starvation counter: counts cycles a debug request has waited and
// flags when the forced-grant threshold is reached.
module dmem_arbiter_starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter: pipeline has priority, debug takes idle slots
// or a forced one-cycle slot (pipeline stalled) after bounded waiting.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pipe_re,
    input  logic              i_pipe_we,
    input  logic [ADDR_W-1:0] i_pipe_addr,
    input  logic [DATA_W-1:0] i_pipe_wdata,
    output logic [DATA_W-1:0] o_pipe_rdata,
    output logic              o_pipe_stall,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout
);

    logic w_busy;
    logic w_hit;
    logic w_gnt;
    logic w_force;
    logic w_rd_gnt;

    rd_state_e         r_state;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    assign w_busy = i_pipe_re | i_pipe_we;

    // Grants are masked by reset so nothing reaches the RAM while it is asserted.
    assign w_gnt    = i_reset & i_dbg_req & (~w_busy | w_hit);
    assign w_force  = i_reset & i_dbg_req & w_busy & w_hit;
    assign w_rd_gnt = w_gnt & ~i_dbg_we;

    dmem_arbiter_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_gnt | ~i_dbg_req),
        .i_inc   (i_dbg_req & ~w_gnt),
        .o_hit   (w_hit)
    );

    assign o_dbg_gnt    = w_gnt;
    assign o_pipe_stall = w_force;
    assign o_ram_we     = i_reset & (w_gnt ? i_dbg_we : i_pipe_we);
    assign o_ram_addr   = w_gnt ? i_dbg_addr  : i_pipe_addr;
    assign o_ram_din    = w_gnt ? i_dbg_wdata : i_pipe_wdata;
    assign o_pipe_rdata = i_ram_dout;

    // RD_WAIT marks the cycle read data sits on the RAM output; staying in
    // RD_WAIT on a back-to-back grant plus r_rvalid forms the 2-deep pipe.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= (r_state == ST_RD_WAIT);
            if (r_state == ST_RD_WAIT) begin
                r_rdata <= i_ram_dout;
            end
            case (r_state)
                ST_IDLE:    r_state <= w_rd_gnt ? ST_RD_WAIT : ST_IDLE;
                ST_RD_WAIT: r_state <= w_rd_gnt ? ST_RD_WAIT : ST_RD_DONE;
                ST_RD_DONE: r_state <= w_rd_gnt ? ST_RD_WAIT : ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_dbg_rvalid = r_rvalid;
    assign o_dbg_rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model with its own memory image.
module tb_dmem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          pipe_re, pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wdata, pipe_rdata;
    logic          pipe_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_pipe_re    (pipe_re),
        .i_pipe_we    (pipe_we),
        .i_pipe_addr  (pipe_addr),
        .i_pipe_wdata (pipe_wdata),
        .o_pipe_rdata (pipe_rdata),
        .o_pipe_stall (pipe_stall),
        .i_dbg_req    (dbg_req),
        .i_dbg_we     (dbg_we),
        .i_dbg_addr   (dbg_addr),
        .i_dbg_wdata  (dbg_wdata),
        .o_dbg_gnt    (dbg_gnt),
        .o_dbg_rvalid (dbg_rvalid),
        .o_dbg_rdata  (dbg_rdata),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_din    (ram_din),
        .i_ram_dout   (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: synchronous, read-first, one-cycle read latency.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    // Reference model state.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] model_mem [DEPTH];
    rd_t           rd_q [$];
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_dout;
    int            cyc;
    int            req_start;
    bit            req_active;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram[a]       = d;
        model_mem[a] = d;
    endtask

    // One clock cycle: drive at negedge, compare shortly after, advance model.
    task automatic step(input logic pre, input logic pwe, input logic [AW-1:0] pa,
                        input logic [DW-1:0] pwd, input logic dreq, input logic dwe,
                        input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                        output logic g);
        logic          busy, egnt, estall, ewe, erv;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, rd;
        int            waited;
        @(negedge clk);
        pipe_re = pre;  pipe_we = pwe;  pipe_addr = pa;  pipe_wdata = pwd;
        dbg_req = dreq; dbg_we = dwe;   dbg_addr = da;   dbg_wdata = dwd;
        #1;
        busy = pre | pwe;
        if (dreq && !req_active) req_start = cyc;
        waited = cyc - req_start;
        egnt   = dreq && (!busy || waited >= MW - 1);
        estall = dreq && busy && (waited >= MW - 1);
        ea  = egnt ? da  : pa;
        ed  = egnt ? dwd : pwd;
        ewe = egnt ? dwe : pwe;
        erv = (rd_q.size() > 0) && (rd_q[0].due == cyc);
        if (erv) begin
            exp_rdata = rd_q[0].d;
            void'(rd_q.pop_front());
        end
        check("dbg_gnt",    64'(dbg_gnt),    64'(egnt));
        check("pipe_stall", 64'(pipe_stall), 64'(estall));
        check("ram_we",     64'(ram_we),     64'(ewe));
        check("ram_addr",   64'(ram_addr),   64'(ea));
        check("ram_din",    64'(ram_din),    64'(ed));
        check("dbg_rvalid", 64'(dbg_rvalid), 64'(erv));
        check("dbg_rdata",  64'(dbg_rdata),  64'(exp_rdata));
        check("pipe_rdata", 64'(pipe_rdata), 64'(exp_dout));
        rd = model_mem[ea];
        if (egnt && !dwe) rd_q.push_back(rd_t'{due: cyc + 2, d: rd});
        if (ewe) model_mem[ea] = ed;
        exp_dout   = rd;
        req_active = dreq && !egnt;
        cyc++;
        g = dbg_gnt;
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, g);
    endtask

    // Reset with a pending request and a store on the inputs: both must be masked.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pipe_re = 0; pipe_we = 1; pipe_addr = '0; pipe_wdata = 32'hFFFF_FFFF;
        dbg_req = 1; dbg_we = 1;  dbg_addr = '0;  dbg_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("rst_gnt",    64'(dbg_gnt),    64'd0);
            check("rst_stall",  64'(pipe_stall), 64'd0);
            check("rst_ram_we", 64'(ram_we),     64'd0);
            check("rst_rvalid", 64'(dbg_rvalid), 64'd0);
            check("rst_rdata",  64'(dbg_rdata),  64'd0);
            if (k == 0) @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        pipe_we = 0; dbg_req = 0; dbg_we = 0; pipe_wdata = '0; dbg_wdata = '0;
        rd_q.delete();
        exp_rdata  = '0;
        req_active = 0;
        exp_dout   = model_mem[0];
    endtask

    initial begin
        logic          g;
        int            lat;
        bit            d_on, d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wd;
        int            kind;
        int            idle_div;

        n_cmp = 0; n_bad = 0; cyc = 0; req_start = 0; req_active = 0;
        exp_rdata = '0; exp_dout = '0;
        rst_n = 1'b0;
        pipe_re = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
        dbg_req = 0; dbg_we = 0;  dbg_addr = '0;  dbg_wdata = '0;
        for (int i = 0; i < DEPTH; i++) preload(AW'(i), '0);
        ram_dout = '0;

        do_reset();

        // Idle-slot debug read.
        preload(13'h010, 32'hDEAD_BEEF);
        step(0, 0, '0, '0, 1, 0, 13'h010, '0, g);
        check("idle_gnt", 64'(g), 64'd1);
        idle(2);
        check("idle_rdata", 64'(dbg_rdata), 64'hDEAD_BEEF);
        idle(2);

        // Forced grant under continuous pipeline loads.
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, AW'($urandom_range(0, 15)), '0, 1, 1, 13'h020, 32'h1234_5678, g);
            if (g) begin
                lat = i;
                break;
            end
        end
        check("force_latency", 64'(lat), 64'd7);
        step(1, 0, 13'h020, '0, 0, 0, '0, '0, g);
        step(0, 0, '0, '0, 0, 0, '0, '0, g);
        check("force_pipe_rd", 64'(pipe_rdata), 64'h1234_5678);

        // Pipeline stores win; debug read lands in the following idle gap.
        for (int i = 0; i < 4; i++)
            step(0, 1, 13'h030, 32'hA5A5_A5A5, 1, 0, 13'h030, '0, g);
        step(0, 0, '0, '0, 1, 0, 13'h030, '0, g);
        check("prio_gnt", 64'(g), 64'd1);
        idle(2);
        check("prio_rdata", 64'(dbg_rdata), 64'hA5A5_A5A5);

        // Back-to-back idle-slot reads.
        preload(13'h001, 32'd1);
        preload(13'h002, 32'd2);
        step(0, 0, '0, '0, 1, 0, 13'h001, '0, g);
        step(0, 0, '0, '0, 1, 0, 13'h002, '0, g);
        idle(1);
        check("b2b_first", 64'(dbg_rdata), 64'd1);
        idle(1);
        check("b2b_second", 64'(dbg_rdata), 64'd2);
        idle(2);

        // Abandoned request, then a fresh one must wait the full period again.
        for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 1, 0, 13'h040, '0, g);
        step(1, 0, '0, '0, 0, 0, '0, '0, g);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, '0, '0, 1, 0, 13'h040, '0, g);
            if (g) begin
                lat = i;
                break;
            end
        end
        check("abandon_latency", 64'(lat), 64'd7);
        idle(3);

        // Randomized traffic with varying pipeline load.
        d_on = 0; d_we = 0; d_addr = '0; d_wd = '0;
        for (int i = 0; i < 3000; i++) begin
            idle_div = ((i / 500) % 2 == 1) ? 7 : 1;
            if (!d_on && $urandom_range(0, 3) == 0) begin
                d_on   = 1;
                d_we   = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom_range(0, 15));
                d_wd   = $urandom;
            end else if (d_on && $urandom_range(0, 31) == 0) begin
                d_on = 0;
            end
            kind = ($urandom_range(0, idle_div) == 0) ? 0 : $urandom_range(1, 3);
            step(1'(kind == 1 || kind == 3), 1'(kind >= 2), AW'($urandom_range(0, 15)),
                 $urandom, d_on, d_we, d_addr, d_wd, g);
            if (g) d_on = 0;
        end
        idle(3);

        // Reset the cycle after a debug read grant: the read must vanish.
        preload(13'h050, 32'hCAFE_F00D);
        step(0, 0, '0, '0, 1, 0, 13'h050, '0, g);
        check("rstrd_gnt", 64'(g), 64'd1);
        do_reset();
        idle(4);
        check("rstrd_rdata", 64'(dbg_rdata), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data RAM (rammemory) of the MEM stage between the pipeline and the debug/loader unit. Pipeline has priority. Debug gets idle slots, or a forced one-cycle slot after bounded waiting, with the pipeline stalled for that cycle. Sits between the mem stage and rammemory, and owns the RAM's wea/addra/dina.

Parameters:
ADDR_W, 13, RAM word-address width
DATA_W, 32, RAM data width
MAX_WAIT, 8, debug wait cycles before a forced grant (range 2..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
pipe_re  in  1  MEM-stage load this cycle
pipe_we  in  1  MEM-stage store this cycle
pipe_addr  in  ADDR_W  MEM-stage address
pipe_wdata  in  DATA_W  store data (already forwarded)
pipe_rdata  out  DATA_W  load data, = ram_dout
pipe_stall  out  1  pipeline must hold MEM and earlier stages this cycle
dbg_req  in  1  debug access request, held until dbg_gnt
dbg_we  in  1  1=write, 0=read; stable while dbg_req
dbg_addr  in  ADDR_W  debug address; stable while dbg_req
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  one-cycle pulse: debug access issued this cycle
dbg_rvalid  out  1  one-cycle pulse: dbg_rdata holds read result
dbg_rdata  out  DATA_W  registered debug read data
ram_we  out  1  to rammemory wea
ram_addr  out  ADDR_W  to rammemory addra
ram_din  out  DATA_W  to rammemory dina
ram_dout  in  DATA_W  from rammemory douta (1-cycle synchronous read)

Behaviour:
- RAM model: access issued in cycle N; read data on ram_dout in N+1.
- pipe_busy = pipe_re | pipe_we. If both are set, treat as a write.
- Owner per cycle is combinational from inputs plus registered state:
  - grant_idle = dbg_req & ~pipe_busy.
  - grant_force = dbg_req & pipe_busy & (wait_cnt == MAX_WAIT-1).
  - dbg_gnt = grant_idle | grant_force.
  - pipe_stall = grant_force.
- Debug owns RAM when dbg_gnt: ram_addr=dbg_addr, ram_din=dbg_wdata, ram_we=dbg_we.
- Otherwise ram_addr=pipe_addr, ram_din=pipe_wdata, ram_we=pipe_we.
- wait_cnt (8-bit reg):
  - clears on dbg_gnt or ~dbg_req;
  - increments each cycle dbg_req & ~dbg_gnt;
  - saturates at MAX_WAIT-1.
- A forced grant always leaves the next cycle to the pipeline, because wait_cnt restarts from 0. Idle-slot grants may be back-to-back.
- Read-response FSM, states IDLE, RD_WAIT, RD_DONE:
  - IDLE -> RD_WAIT when dbg_gnt & ~dbg_we.
  - RD_WAIT: capture dbg_rdata <= ram_dout; -> RD_DONE.
  - RD_DONE: dbg_rvalid=1 for exactly this cycle. -> RD_WAIT if another debug read is granted this cycle, else IDLE.
  - Read latency: gnt in N, rvalid/rdata in N+2.
  - A grant in RD_WAIT (back-to-back reads) is legal; a 2-deep capture pipeline keeps one rvalid per granted read, in order.
- Debug writes produce no rvalid and complete in the gnt cycle.
- pipe_rdata is raw ram_dout. In the cycle after a forced grant it may carry debug data. The pipeline held its state during the stall, so it re-issues and consumes correct data one cycle later.
- dbg_req deasserted before grant: request abandoned, no gnt, wait_cnt cleared.
- Reset (reset=0, async):
  - FSM -> IDLE; wait_cnt=0; dbg_rdata=0; dbg_rvalid=0.
  - ram_we, dbg_gnt and pipe_stall forced 0 while reset is asserted.
  - A read in flight is dropped: no rvalid after reset release.
- After reset release, the first cycle follows normal rules.

Decomposition:
- Shared header dmem_arb_defs.vh: FSM state encodings (IDLE=2'd0, RD_WAIT=2'd1, RD_DONE=2'd2), default ADDR_W/DATA_W/MAX_WAIT.
- One natural sub-module: dmem_starve_cnt, the saturating wait counter with clear/inc/hit-limit output. Arbitration mux and FSM stay in dmem_arbiter.

Test Plan:
- Idle read: no pipe traffic; RAM[0x010]=0xDEADBEEF; dbg_req read 0x010 -> dbg_gnt same cycle, dbg_rvalid+dbg_rdata=0xDEADBEEF two cycles later, pipe_stall never 1.
- Forced grant: pipe_re every cycle, dbg_req write 0x020=0x12345678, MAX_WAIT=8 -> dbg_gnt and pipe_stall together exactly 7 cycles after req; ram_we=1, ram_addr=0x020 that cycle; later pipe read of 0x020 returns 0x12345678.
- Pipeline priority: pipe_we 0x030=0xA5A5A5A5 each cycle while debug reads 0x030 under an idle gap -> RAM written by pipe; debug read in idle slot returns 0xA5A5A5A5.
- Back-to-back debug reads in idle cycles, 0x001 then 0x002 (values 1, 2) -> two rvalid pulses on consecutive cycles, data 1 then 2, in order.
- Abandon: dbg_req for 3 busy cycles then dropped -> no dbg_gnt; a new req under busy traffic waits a full 7 cycles again.
- Reset mid-read: assert reset=0 the cycle after a debug read gnt -> outputs 0 immediately, no dbg_rvalid after release, dbg_rdata=0.
